// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, controller command codes and burst-length helper for DMA ports
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

  localparam logic [2:0] DMA_CMD_READ  = 3'b001;
  localparam logic [2:0] DMA_CMD_WRITE = 3'b000;

  // Controller burst length is in 32-bit words, minus one
  function automatic logic [5:0] dma_cmd_bl(input int burst_len);
    return 6'(burst_len / 2 - 1);
  endfunction

endpackage

// File: rtl/dma_read_port.sv
// dma_read_port: issues one burst read per request and unpacks 32-bit controller words into a 16-bit stream
module dma_read_port
  import dma_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reads_en,
  input  logic [ADDR_W-1:0] addr,
  output logic              ob_we,
  output logic [15:0]       ob_data,
  output logic              burst_done,
  output logic              busy,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  input  logic              rd_empty,
  input  logic              rd_error,
  output logic              err
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  state_e            state_q;
  logic [ADDR_W-2:0] addr_q;
  logic [15:0]       hold_q;
  logic [CW-1:0]     cnt_q;
  logic              ob_we_q;
  logic [15:0]       ob_data_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic              last;
  logic              pop;
  logic              addr_msb_unused;

  // Word address MSB falls off when converting to a byte address
  assign addr_msb_unused = addr[ADDR_W-1];

  assign last    = cnt_q == CW'(BURST_LEN - 2);
  assign pop     = !rd_empty && (state_q == S_FETCH || (state_q == S_HI && !last));
  assign rd_en   = pop;
  assign cmd_en  = state_q == S_CMD && !cmd_full;

  assign cmd_instr     = DMA_CMD_READ;
  assign cmd_bl        = dma_cmd_bl(BURST_LEN);
  assign cmd_byte_addr = {addr_q, 1'b0};
  assign ob_we         = ob_we_q;
  assign ob_data       = ob_data_q;
  assign burst_done    = done_q;
  assign busy          = busy_q;
  assign err           = err_q;

  // Burst FSM: the low half goes out the cycle after a pop, the held high half the cycle after that
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      ob_we_q   <= 1'b0;
      ob_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q   <= err_q | rd_error;
      ob_we_q <= 1'b0;
      done_q  <= 1'b0;
      if (pop) begin
        hold_q    <= rd_data[31:16];
        ob_we_q   <= 1'b1;
        ob_data_q <= rd_data[15:0];
      end
      case (state_q)
        S_IDLE: if (reads_en) begin
          addr_q  <= addr[ADDR_W-2:0];
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_CMD;
        end
        S_CMD: if (!cmd_full) state_q <= S_FETCH;
        S_FETCH: if (!rd_empty) state_q <= S_LO;
        S_LO: begin
          ob_we_q   <= 1'b1;
          ob_data_q <= hold_q;
          state_q   <= S_HI;
        end
        S_HI: begin
          cnt_q   <= cnt_q + CW'(2);
          done_q  <= last;
          state_q <= last ? S_DONE : (rd_empty ? S_FETCH : S_LO);
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_port.sv
// tb_dma_read_port: directed vector table plus hand sequences against a modelled controller FIFO
module tb_dma_read_port;

  localparam int BL = 16;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reads_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ob_we;
  logic [15:0]   ob_data;
  logic          burst_done;
  logic          busy;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
  logic          cmd_full = 1'b0;
  logic          rd_en;
  logic [31:0]   rd_data = '0;
  logic          rd_empty = 1'b1;
  logic          rd_error = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  dma_read_port #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .reads_en(reads_en), .addr(addr),
    .ob_we(ob_we), .ob_data(ob_data), .burst_done(burst_done), .busy(busy),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_error(rd_error), .err(err)
  );

  int checks = 0;
  int errors = 0;

  int            cyc = 0;
  int            pop_cnt = 0;
  int            nw = 0;
  int            ncmd = 0;
  int            ndone = 0;
  int            viol_rd = 0;
  int            viol_cmd = 0;
  int            last_we_c = 0;
  int            done_c = 0;
  int            avail = 0;
  bit            starve = 0;
  bit            adv = 0;
  logic [AW-1:0] base = '0;
  logic [15:0]   got[64];
  logic [AW-1:0] cmd_a[4];
  int            cmd_cy[4];

  // Controller FIFO word j is {2j+1, 2j}, so delivered 16-bit word i must equal i.
  // Inputs change on the falling edge; outputs are observed 1ns later, before the rising edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    rd_empty = (starve && ((cyc / 3) % 2 == 0)) || pop_cnt >= avail;
    rd_data  = {16'(2 * pop_cnt + 1), 16'(2 * pop_cnt)};
    addr     = base + (adv ? AW'(16 * ndone) : AW'(0));
    #1;
    if (!rst) begin
      pop_cnt = 0; nw = 0; ncmd = 0; ndone = 0; viol_rd = 0; viol_cmd = 0;
    end else begin
      if (rd_en) begin
        if (rd_empty) viol_rd++;
        pop_cnt++;
      end
      if (ob_we) begin
        if (nw < 64) got[nw] = ob_data;
        nw++;
        last_we_c = cyc;
      end
      if (cmd_en) begin
        if (cmd_full) viol_cmd++;
        if (ncmd < 4) begin
          cmd_a[ncmd]  = cmd_byte_addr;
          cmd_cy[ncmd] = cyc;
        end
        ncmd++;
      end
      if (burst_done) begin
        ndone++;
        done_c = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input int n);
    int bad = 0;
    for (int i = 0; i < n && i < 64; i++) if (got[i] !== 16'(i)) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; reads_en = 1'b0; cmd_full = 1'b0; rd_error = 1'b0; adv = 1'b0; starve = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    string         nm;
    logic [AW-1:0] a;
    int            cf;
    bit            stv;
    int            av;
    logic [AW-1:0] exp_ca;
    int            exp_w;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    int t0;
    do_reset();
    base = v.a; avail = v.av; starve = v.stv;
    @(negedge clk);
    reads_en = 1'b1;
    cmd_full = v.cf > 0;
    #2 t0 = cyc;
    repeat (v.cf) @(negedge clk);
    cmd_full = 1'b0;
    for (int i = 0; i < 400 && ncmd == 0; i++) @(negedge clk);
    reads_en = 1'b0;
    for (int i = 0; i < 400 && ndone == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2;
    chk({v.nm, " ncmd"}, 64'(ncmd), 64'd1);
    chk({v.nm, " cmd_byte_addr"}, 64'(cmd_a[0]), 64'(v.exp_ca));
    chk({v.nm, " cmd cycle"}, 64'(cmd_cy[0] - t0), 64'(v.cf > 1 ? v.cf : 1));
    chk({v.nm, " words"}, 64'(nw), 64'(v.exp_w));
    chk_data({v.nm, " data"}, v.exp_w);
    chk({v.nm, " rd_en while empty"}, 64'(viol_rd), 64'd0);
    chk({v.nm, " cmd_en while full"}, 64'(viol_cmd), 64'd0);
    chk({v.nm, " ndone"}, 64'(ndone), 64'd1);
    chk({v.nm, " done after last word"}, 64'(done_c - last_we_c), 64'd1);
    chk({v.nm, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{nm: "basic",  a: 30'h100,       cf: 0, stv: 0, av: 8,    exp_ca: 30'h200, exp_w: 16};
    vecs[1] = '{nm: "bp",     a: 30'h040,       cf: 5, stv: 0, av: 1000, exp_ca: 30'h080, exp_w: 16};
    vecs[2] = '{nm: "starve", a: 30'h2000_0001, cf: 0, stv: 1, av: 1000, exp_ca: 30'h002, exp_w: 16};
    vecs[3] = '{nm: "mixed",  a: 30'h0AB,       cf: 2, stv: 1, av: 1000, exp_ca: 30'h156, exp_w: 16};

    #1;
    chk("reset strobes", {58'd0, ob_we, burst_done, busy, cmd_en, rd_en, err}, 64'd0);
    chk("reset ob_data", 64'(ob_data), 64'd0);
    chk("reset cmd_byte_addr", 64'(cmd_byte_addr), 64'd0);
    chk("cmd_instr", 64'(cmd_instr), 64'd1);
    chk("cmd_bl", 64'(cmd_bl), 64'd7);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Back-to-back bursts with the engine advancing addr on each burst_done
    do_reset();
    base = '0; adv = 1'b1; avail = 1000;
    @(negedge clk);
    reads_en = 1'b1;
    for (int i = 0; i < 400 && ndone < 2; i++) @(negedge clk);
    reads_en = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("b2b ndone", 64'(ndone), 64'd2);
    chk("b2b ncmd", 64'(ncmd), 64'd2);
    chk("b2b addr0", 64'(cmd_a[0]), 64'h000);
    chk("b2b addr1", 64'(cmd_a[1]), 64'h020);
    chk("b2b period", 64'(cmd_cy[1] - cmd_cy[0]), 64'(BL + 4));
    chk("b2b words", 64'(nw), 64'd32);
    chk_data("b2b data", 32);

    // Request dropped after four words: the burst still drains
    do_reset();
    base = 30'h10; avail = 1000;
    @(negedge clk);
    reads_en = 1'b1;
    for (int i = 0; i < 400 && nw < 4; i++) @(negedge clk);
    reads_en = 1'b0;
    for (int i = 0; i < 400 && ndone == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2;
    chk("drop words", 64'(nw), 64'd16);
    chk("drop ncmd", 64'(ncmd), 64'd1);
    chk("drop ndone", 64'(ndone), 64'd1);
    chk_data("drop data", 16);

    // Asynchronous reset after word 6, then a fresh request with an error pulse
    do_reset();
    base = '0; avail = 1000;
    @(negedge clk);
    reads_en = 1'b1;
    for (int i = 0; i < 400 && nw < 6; i++) @(negedge clk);
    chk("mid words before reset", 64'(nw >= 6), 64'd1);
    rst = 1'b0;
    reads_en = 1'b0;
    #1;
    chk("mid reset strobes", {58'd0, ob_we, burst_done, busy, cmd_en, rd_en, err}, 64'd0);
    chk("mid reset ob_data", 64'(ob_data), 64'd0);
    chk("mid reset cmd_byte_addr", 64'(cmd_byte_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("post reset idle", 64'(busy), 64'd0);
    chk("post reset no cmd", 64'(ncmd), 64'd0);
    @(negedge clk);
    reads_en = 1'b1;
    rd_error = 1'b1;
    @(negedge clk);
    rd_error = 1'b0;
    for (int i = 0; i < 400 && ncmd == 0; i++) @(negedge clk);
    reads_en = 1'b0;
    for (int i = 0; i < 400 && ndone == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    chk("fresh words", 64'(nw), 64'd16);
    chk_data("fresh data", 16);
    chk("err sticky", 64'(err), 64'd1);
    do_reset();
    #2;
    chk("err cleared by reset", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
